// File: rtl/event_monitor_pkg.sv
// Shared types and event-record field helpers for the event monitor.
// The helpers decode records built with the default widths below.
package event_monitor_pkg;

  localparam int unsigned EVMON_PROBE_W = 8;
  localparam int unsigned EVMON_ID_W    = 4;
  localparam int unsigned EVMON_TS_W    = 16;
  localparam int unsigned EVMON_EVT_W   = EVMON_TS_W + EVMON_ID_W + EVMON_PROBE_W;

  localparam int unsigned EVMON_DATA_LSB = 0;
  localparam int unsigned EVMON_ID_LSB   = EVMON_PROBE_W;
  localparam int unsigned EVMON_TS_LSB   = EVMON_PROBE_W + EVMON_ID_W;

  typedef enum logic [1:0] {
    MATCH    = 2'd0,
    MISMATCH = 2'd1,
    CHANGE   = 2'd2,
    RISE     = 2'd3
  } trig_mode_e;

  function automatic logic [EVMON_TS_W-1:0] get_ts(input logic [EVMON_EVT_W-1:0] evt);
    return evt[EVMON_TS_LSB +: EVMON_TS_W];
  endfunction

  function automatic logic [EVMON_ID_W-1:0] get_id(input logic [EVMON_EVT_W-1:0] evt);
    return evt[EVMON_ID_LSB +: EVMON_ID_W];
  endfunction

  function automatic logic [EVMON_PROBE_W-1:0] get_data(input logic [EVMON_EVT_W-1:0] evt);
    return evt[EVMON_DATA_LSB +: EVMON_PROBE_W];
  endfunction

endpackage

// File: rtl/event_monitor_if.sv
// Event read-out port: FIFO head, valid flag and pop from the bus front end.
interface event_monitor_if #(
  parameter int unsigned EVT_W = event_monitor_pkg::EVMON_EVT_W
);

  logic [EVT_W-1:0] evt_data;
  logic             evt_valid;
  logic             evt_pop;

  modport master (output evt_data, output evt_valid, input evt_pop);
  modport slave  (input evt_data, input evt_valid, output evt_pop);

endinterface

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO; a push on a full FIFO is
// accepted only when a pop happens on the same edge.
module event_fifo #(
  parameter int unsigned WIDTH = 28,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | pop);
  assign overflow  = push & full & ~pop;
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop_c) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push_c, do_pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/event_monitor_core.sv
// Event monitor: masked trigger on a tagged probe bus, timestamped capture into an FWFT FIFO.
// Edge trigger modes (CHANGE/RISE) are built only when EVMON_EDGE_TRIG_EN is defined.
module event_monitor_core
  import event_monitor_pkg::*;
#(
  parameter int unsigned PROBE_W    = 8,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               arm,
  input  logic [1:0]         trig_mode,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [ID_W-1:0]    probe_id,
  input  logic [PROBE_W-1:0] probe_data,
  event_monitor_if.master    evt,
  output logic               triggered_sticky,
  output logic               fifo_overflow_sticky
);

  localparam int unsigned EVT_W = TS_W + ID_W + PROBE_W;

  logic [TS_W-1:0]  ts;
  logic             cap_valid;
  logic [EVT_W-1:0] cap_data;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_ovf;
  trig_mode_e       mode_c;
  logic             match_c;
  logic             cond_c;
  logic             hit_c;

`ifdef EVMON_EDGE_TRIG_EN
  logic [PROBE_W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     prev <= '0;
    else if (en) prev <= probe_data;
  end
`endif

  assign mode_c  = trig_mode_e'(trig_mode);
  assign match_c = (((probe_data ^ trig_value) & trig_mask) == '0);

  // Trigger condition per mode; edge modes fall to default when not built
  always_comb begin
    cond_c = 1'b0;
    case (mode_c)
      MATCH:    cond_c = match_c;
      MISMATCH: cond_c = ~match_c;
`ifdef EVMON_EDGE_TRIG_EN
      CHANGE:   cond_c = |((probe_data ^ prev) & trig_mask);
      RISE:     cond_c = |(probe_data & ~prev & trig_mask);
`endif
      default:  cond_c = 1'b0;
    endcase
  end

  assign hit_c = en & arm & cond_c;

  // Timestamp, capture stage and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts                   <= '0;
      cap_valid            <= 1'b0;
      cap_data             <= '0;
      triggered_sticky     <= 1'b0;
      fifo_overflow_sticky <= 1'b0;
    end else begin
      if (en) ts <= ts + TS_W'(1);
      cap_valid <= hit_c;
      if (hit_c) cap_data <= {ts, probe_id, probe_data};
      if (!arm)       triggered_sticky <= 1'b0;
      else if (hit_c) triggered_sticky <= 1'b1;
      if (fifo_ovf) fifo_overflow_sticky <= 1'b1;
    end
  end

  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cap_valid),
    .pop      (evt.evt_pop),
    .wdata    (cap_data),
    .rdata    (evt.evt_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (fifo_ovf)
  );

  assign evt.evt_valid = ~fifo_empty;

  a_ovf_only_when_full: assert property (@(posedge clk) disable iff (rst) fifo_ovf |-> fifo_full);

endmodule

// File: tb/tb_event_monitor_core.sv
// Self-checking bench for event_monitor_core: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_event_monitor_core;
  import event_monitor_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef EVMON_EDGE_TRIG_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en, arm;
  logic [1:0] trig_mode;
  logic [7:0] trig_value, trig_mask, probe_data;
  logic [3:0] probe_id;
  logic       triggered_sticky, fifo_overflow_sticky;

  event_monitor_if #(.EVT_W(28)) evt_if ();

  event_monitor_core #(
    .PROBE_W(8), .ID_W(4), .TS_W(16), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .en                   (en),
    .arm                  (arm),
    .trig_mode            (trig_mode),
    .trig_value           (trig_value),
    .trig_mask            (trig_mask),
    .probe_id             (probe_id),
    .probe_data           (probe_data),
    .evt                  (evt_if),
    .triggered_sticky     (triggered_sticky),
    .fifo_overflow_sticky (fifo_overflow_sticky)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: event queue plus the few visible registers
  logic [27:0] mq[$];
  int unsigned m_ts;
  logic [7:0]  m_prev;
  bit          m_sticky, m_ovf, m_cap_v;
  logic [27:0] m_cap;

  task automatic model_reset();
    mq.delete();
    m_ts = 0; m_prev = 8'h00; m_sticky = 1'b0; m_ovf = 1'b0;
    m_cap_v = 1'b0; m_cap = '0;
  endtask

  // Advance the model by one edge from the current inputs, then the DUT
  task automatic tick();
    bit cond, hit;
    logic [7:0] m;
    m = trig_mask;
    case (trig_mode)
      2'd0:    cond = (probe_data & m) == (trig_value & m);
      2'd1:    cond = (probe_data & m) != (trig_value & m);
      2'd2:    cond = EDGE_EN && (((probe_data ^ m_prev) & m) != 8'h00);
      default: cond = EDGE_EN && ((probe_data & ~m_prev & m) != 8'h00);
    endcase
    hit = en && arm && cond;
    if (evt_if.evt_pop && mq.size() > 0) mq.delete(0);
    if (m_cap_v) begin
      if (mq.size() < DEPTH) mq.push_back(m_cap);
      else m_ovf = 1'b1;
    end
    m_cap_v = hit;
    m_cap   = {16'(m_ts), probe_id, probe_data};
    if (!arm) m_sticky = 1'b0;
    else if (hit) m_sticky = 1'b1;
    if (en) begin
      m_ts   = (m_ts + 1) % 65536;
      m_prev = probe_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0; arm = 1'b0; trig_mode = 2'd0; trig_value = 8'h00; trig_mask = 8'h00;
    probe_id = 4'd0; probe_data = 8'h00; evt_if.evt_pop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_match(input logic [7:0] mask, input logic [7:0] val, input logic [3:0] id);
    en = 1'b1; arm = 1'b1; trig_mode = 2'd0; trig_mask = mask; trig_value = val; probe_id = id;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0; arm = 1'b0; trig_mode = 2'd0; trig_value = 8'h00; trig_mask = 8'h00;
    probe_id = 4'd0; probe_data = 8'h00; evt_if.evt_pop = 1'b0;
    @(negedge clk);
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_data !== 28'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", evt_if.evt_data); end
    n_cmp++; if (triggered_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_trig: got %b expected 0", triggered_sticky); end
    n_cmp++; if (fifo_overflow_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", fifo_overflow_sticky); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_match();
    do_reset();
    set_match(8'hFF, 8'hA5, 4'd3);
    probe_data = 8'h00;
    tick();
    n_cmp++; if (triggered_sticky !== 1'b0) begin n_bad++; $display("FAIL match_no_trig: got %b expected 0", triggered_sticky); end
    probe_data = 8'hA5;
    tick();
    n_cmp++; if (triggered_sticky !== 1'b1) begin n_bad++; $display("FAIL match_trig: got %b expected 1", triggered_sticky); end
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL match_valid_early: got %b expected 0", evt_if.evt_valid); end
    probe_data = 8'h00;
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1) begin n_bad++; $display("FAIL match_valid: got %b expected 1", evt_if.evt_valid); end
    n_cmp++; if (get_id(evt_if.evt_data) !== 4'd3) begin n_bad++; $display("FAIL match_id: got %h expected 3", get_id(evt_if.evt_data)); end
    n_cmp++; if (get_data(evt_if.evt_data) !== 8'hA5) begin n_bad++; $display("FAIL match_data: got %h expected a5", get_data(evt_if.evt_data)); end
    n_cmp++; if (get_ts(evt_if.evt_data) !== 16'd1) begin n_bad++; $display("FAIL match_ts: got %0d expected 1", get_ts(evt_if.evt_data)); end
    evt_if.evt_pop = 1'b1;
    tick();
    evt_if.evt_pop = 1'b0;
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL match_drained: got %b expected 0", evt_if.evt_valid); end
  endtask

  task automatic test_continuous();
    do_reset();
    set_match(8'hFF, 8'hA5, 4'd7);
    probe_data = 8'hA5;
    repeat (6) tick();
    n_cmp++; if (fifo_overflow_sticky !== 1'b1) begin n_bad++; $display("FAIL cont_ovf: got %b expected 1", fifo_overflow_sticky); end
    probe_data = 8'h00;
    tick();
    evt_if.evt_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (evt_if.evt_valid !== 1'b1) begin n_bad++; $display("FAIL cont_valid[%0d]: got %b expected 1", i, evt_if.evt_valid); end
      n_cmp++; if (get_ts(evt_if.evt_data) !== 16'(i)) begin n_bad++; $display("FAIL cont_ts[%0d]: got %0d expected %0d", i, get_ts(evt_if.evt_data), i); end
      tick();
    end
    evt_if.evt_pop = 1'b0;
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL cont_empty: got %b expected 0", evt_if.evt_valid); end
  endtask

  task automatic test_mask();
    do_reset();
    set_match(8'hF0, 8'hA0, 4'd5);
    probe_data = 8'hAF;
    tick();
    probe_data = 8'hB0;
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b1) begin n_bad++; $display("FAIL mask_valid: got %b expected 1", evt_if.evt_valid); end
    n_cmp++; if (get_data(evt_if.evt_data) !== 8'hAF) begin n_bad++; $display("FAIL mask_data: got %h expected af", get_data(evt_if.evt_data)); end
    probe_data = 8'h00;
    evt_if.evt_pop = 1'b1;
    tick();
    evt_if.evt_pop = 1'b0;
    tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL mask_no_hit: got %b expected 0", evt_if.evt_valid); end
  endtask

  task automatic test_edge_modes();
    int cnt;
    do_reset();
    en = 1'b1; arm = 1'b0; trig_mode = 2'd2; trig_mask = 8'hFF; trig_value = 8'h00; probe_id = 4'd1;
    probe_data = 8'h00;
    tick();
    arm = 1'b1;
    probe_data = 8'h01;
    repeat (4) tick();
    n_cmp++; if (triggered_sticky !== EDGE_EN) begin n_bad++; $display("FAIL change_trig: got %b expected %b", triggered_sticky, EDGE_EN); end
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (evt_if.evt_valid) cnt++;
      evt_if.evt_pop = evt_if.evt_valid;
      tick();
    end
    evt_if.evt_pop = 1'b0;
    n_cmp++; if (cnt != (EDGE_EN ? 1 : 0)) begin n_bad++; $display("FAIL change_count: got %0d expected %0d", cnt, EDGE_EN ? 1 : 0); end
    arm = 1'b0; trig_mode = 2'd3;
    tick();
    arm = 1'b1;
    probe_data = 8'h00;
    repeat (4) tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (evt_if.evt_valid) cnt++;
      evt_if.evt_pop = evt_if.evt_valid;
      tick();
    end
    evt_if.evt_pop = 1'b0;
    n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL rise_fall_count: got %0d expected 0", cnt); end
    probe_data = 8'h02;
    repeat (4) tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (evt_if.evt_valid) cnt++;
      evt_if.evt_pop = evt_if.evt_valid;
      tick();
    end
    evt_if.evt_pop = 1'b0;
    n_cmp++; if (cnt != (EDGE_EN ? 1 : 0)) begin n_bad++; $display("FAIL rise_count: got %0d expected %0d", cnt, EDGE_EN ? 1 : 0); end
  endtask

  task automatic test_disarm();
    int cnt;
    do_reset();
    set_match(8'hFF, 8'h3C, 4'd2);
    probe_data = 8'h3C;
    tick();
    n_cmp++; if (triggered_sticky !== 1'b1) begin n_bad++; $display("FAIL disarm_armed: got %b expected 1", triggered_sticky); end
    arm = 1'b0;
    tick();
    n_cmp++; if (triggered_sticky !== 1'b0) begin n_bad++; $display("FAIL disarm_clear: got %b expected 0", triggered_sticky); end
    repeat (3) tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (evt_if.evt_valid) cnt++;
      evt_if.evt_pop = evt_if.evt_valid;
      tick();
    end
    evt_if.evt_pop = 1'b0;
    n_cmp++; if (cnt != 1) begin n_bad++; $display("FAIL disarm_count: got %0d expected 1", cnt); end
  endtask

  task automatic test_full_pop();
    do_reset();
    set_match(8'hFF, 8'h5A, 4'd9);
    probe_data = 8'h5A;
    repeat (5) tick();
    probe_data = 8'h00;
    evt_if.evt_pop = 1'b1;
    tick();
    n_cmp++; if (fifo_overflow_sticky !== 1'b0) begin n_bad++; $display("FAIL full_pop_ovf: got %b expected 0", fifo_overflow_sticky); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (evt_if.evt_valid !== 1'b1 || get_ts(evt_if.evt_data) !== 16'(i)) begin
        n_bad++; $display("FAIL full_pop_head[%0d]: got valid=%b ts=%0d expected valid=1 ts=%0d", i, evt_if.evt_valid, get_ts(evt_if.evt_data), i);
      end
      tick();
    end
    evt_if.evt_pop = 1'b0;
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL full_pop_empty: got %b expected 0", evt_if.evt_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      en         = ($urandom_range(0, 9) != 0);
      arm        = ($urandom_range(0, 19) != 0);
      trig_mode  = 2'($urandom_range(0, 3));
      trig_mask  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      trig_value = 8'($urandom_range(0, 3) == 0 ? 8'hA5 : $urandom_range(0, 255));
      probe_id   = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       probe_data = trig_value;
        1:       probe_data = m_prev;
        default: probe_data = 8'($urandom);
      endcase
      evt_if.evt_pop = ($urandom_range(0, 2) == 0);
      tick();
      n_cmp++; if (evt_if.evt_valid !== (mq.size() != 0)) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, evt_if.evt_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_cmp++; if (evt_if.evt_data !== mq[0]) begin n_bad++; $display("FAIL rand_data[%0d]: got %h expected %h", c, evt_if.evt_data, mq[0]); end
      end
      n_cmp++; if (triggered_sticky !== m_sticky) begin n_bad++; $display("FAIL rand_trig[%0d]: got %b expected %b", c, triggered_sticky, m_sticky); end
      n_cmp++; if (fifo_overflow_sticky !== m_ovf) begin n_bad++; $display("FAIL rand_ovf[%0d]: got %b expected %b", c, fifo_overflow_sticky, m_ovf); end
    end
    evt_if.evt_pop = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_match(8'hFF, 8'h11, 4'd4);
    probe_data = 8'h11;
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b expected 0", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_data !== 28'h0) begin n_bad++; $display("FAIL arst_data: got %h expected 0", evt_if.evt_data); end
    n_cmp++; if (triggered_sticky !== 1'b0) begin n_bad++; $display("FAIL arst_trig: got %b expected 0", triggered_sticky); end
    n_cmp++; if (fifo_overflow_sticky !== 1'b0) begin n_bad++; $display("FAIL arst_ovf: got %b expected 0", fifo_overflow_sticky); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    en = 1'b0;
    repeat (2) tick();
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL arst_capture_lost: got %b expected 0", evt_if.evt_valid); end
  endtask

  initial begin
    test_reset();
    test_match();
    test_continuous();
    test_mask();
    test_edge_modes();
    test_disarm();
    test_full_pop();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/event_monitor_core.md
# event_monitor_core

Event monitor core: samples a tagged probe bus, evaluates a masked trigger each cycle, and logs each qualifying sample as a timestamped event record into a small first-word-fall-through FIFO for software or a bus bridge to drain. Sits between the probed logic and the register/bus front end. The front end supplies the `en`/`arm`/trigger configuration and consumes `evt_data` via `evt_pop`.

## Interface
- `PROBE_W`, default 8: probe data width.
- `ID_W`, default 4: probe source ID width.
- `TS_W`, default 16: timestamp width.
- `FIFO_DEPTH`, default 4: event FIFO entries; power of two, ≥2.
- Derived `EVT_W` = `TS_W`+`ID_W`+`PROBE_W`.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  global enable: sampling, timestamp counting, logging.
- `arm`  in  1  trigger armed; low clears `triggered_sticky`.
- `trig_mode`  in  2  0=match, 1=mismatch, 2=change, 3=rise.
- `trig_value`  in  `PROBE_W`  compare value.
- `trig_mask`  in  `PROBE_W`  bit-enable mask for all modes.
- `probe_id`  in  `ID_W`  source tag stored with the event.
- `probe_data`  in  `PROBE_W`  probed value.
- `evt_pop`  in  1  consume the FIFO head.
- `evt_data`  out  `EVT_W`  FIFO head, packed {ts, id, data}: ts in `[EVT_W-1 -: TS_W]`, id in `[PROBE_W+ID_W-1 -: ID_W]`, data in `[PROBE_W-1:0]`.
- `evt_valid`  out  1  FIFO non-empty.
- `triggered_sticky`  out  1  trigger has fired since arming.
- `fifo_overflow_sticky`  out  1  an event was dropped because the FIFO was full.

## Operation
- **Timestamp.** Counter `ts` increments by 1 every cycle `en`=1 and wraps modulo 2^`TS_W`. It holds when `en`=0.
- **Previous sample.** Register `prev` loads `probe_data` every `en` cycle.
- **Trigger conditions**, with m=`trig_mask`:
  - Mode 0: (`probe_data`&m)==(`trig_value`&m).
  - Mode 1: the mode-0 test is false.
  - Mode 2: ((`probe_data`^`prev`)&m)!=0.
  - Mode 3: (`probe_data`&~`prev`&m)!=0.
- **Hit.** hit = `en`&`arm`&condition. Every hit cycle logs one event; a condition that stays true logs one event per cycle.
- **Capture.** On a hit, {`ts`,`probe_id`,`probe_data`} is registered into a capture stage and pushed to the FIFO on the next edge.
- **Trigger sticky.** `triggered_sticky` is set on a hit and cleared synchronously while `arm`=0.
- **Overflow.** A push while the FIFO is full with no simultaneous pop drops the event and sets `fifo_overflow_sticky`. The flag clears only on reset.
- **Full with pop.** Push and pop in the same cycle on a full FIFO: both are accepted.
- **Pop while empty:** ignored.
- **Pops ignore `en`:** pops are honoured when `en`=0.
- **Disable.** `en`=0 suppresses new hits; a capture already registered still pushes.

## Timing
- **Reset values:** all outputs 0, `ts`=0, `prev`=0, capture stage empty, FIFO empty, memory zeroed.
- **Hit latency:** `probe_data` sampled at edge N gives `triggered_sticky`=1 after edge N, the push at edge N+1, and `evt_valid`=1 after edge N+1.
- **Event timestamp:** the `ts` value at the hit cycle N.
- **FIFO read path:** `evt_data`/`evt_valid` are combinational from FIFO state, first-word-fall-through. A pop at edge K advances the head after K.
- **Reset mid-operation:** all state clears immediately and asynchronously; pending captures are lost.

## Configuration
- **`EVMON_EDGE_TRIG_EN`:** when defined, modes 2 and 3 are implemented with the `prev` register.
- When undefined, `prev` is omitted and modes 2 and 3 never hit. Modes 0 and 1 are unchanged.

## Structure
- **Package `event_monitor_pkg`:**
  - `trig_mode_e` enum: MATCH, MISMATCH, CHANGE, RISE.
  - Field offset helper functions: `get_ts`, `get_id`, `get_data`, parameterised through localparams.
- **Sub-module `event_fifo`:** synchronous first-word-fall-through FIFO with parameters WIDTH and DEPTH; ports push, pop, wdata, rdata, empty, full, overflow pulse. Pointers are clog2(DEPTH) bits with a clog2(DEPTH)+1-bit count.

## Test plan
- **Match trigger:** reset, `en`=`arm`=1, mode 0, mask FF, value A5, id 3, data 00 for one cycle → no trigger. Then data A5 → `triggered_sticky` set after that edge, `evt_valid` one edge later, and the head decodes id=3, data=A5, ts equal to the hit cycle's count.
- **Continuous match:** data held at A5 for 6 cycles with no pops → 4 events logged and `fifo_overflow_sticky`=1. Draining yields consecutive timestamps, then `evt_valid`=0.
- **Mask:** mask F0, value A0, data AF → hit. Data B0 → no hit.
- **Change/rise modes:** mode 2 with data 00→01 → exactly one event. Mode 3 with data 01→00 → no event. With the macro undefined, neither mode ever hits.
- **Disarm:** `arm`=0 → `triggered_sticky` clears and matching data logs nothing.
- **Full FIFO:** push and pop in the same cycle on a full FIFO → no overflow and count unchanged. Async `rst` mid-stream → all outputs 0 immediately.
